// File: rtl/cfg_mc_ro_mem.sv
// Multi-channel read-only memory: round-robin arbitration of CHANS requesters onto one
// ROM array, with a fixed RDLAT-cycle read pipeline returning tagged, one-hot-valid data.
module cfg_mc_ro_mem #(
    parameter int unsigned CHANS  = 4,
    parameter int unsigned BLKS   = 2,
    parameter int unsigned BDEPTH = 32,
    parameter int unsigned SEGS   = 1,
    parameter int unsigned SEGW   = 32,
    parameter int unsigned RDLAT  = 1,
    parameter logic [BLKS-1:0][BDEPTH-1:0][SEGS-1:0][SEGW-1:0] ROMVAL = '0,
    localparam int unsigned NENT  = BLKS * BDEPTH,
    localparam int unsigned AW    = (NENT > 1) ? $clog2(NENT) : 1,
    localparam int unsigned CW    = (CHANS > 1) ? $clog2(CHANS) : 1,
    localparam int unsigned DW    = SEGS * SEGW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANS-1:0]    req,
    input  logic [CHANS*AW-1:0] addr,
    output logic [CHANS-1:0]    gnt,
    output logic [CHANS-1:0]    rvalid,
    output logic [CW-1:0]       rchan,
    output logic [DW-1:0]       rdata
);

    if (RDLAT < 1 || RDLAT > 3) begin : g_bad_rdlat
        $error("cfg_mc_ro_mem: RDLAT must be in 1..3");
    end

    logic [CW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    gidx;
    logic             xfer;
    logic [AW-1:0]    gaddr;
    logic [DW-1:0]    rom_word;
    int unsigned      cand;

    logic [RDLAT-1:0] vld_q;
    logic [CW-1:0]    chan_q [RDLAT];
    logic [DW-1:0]    word_q [RDLAT];

    // Scan ptr, ptr+1, ... modulo CHANS; first requester wins.
    always_comb begin
        gnt  = '0;
        gidx = '0;
        xfer = 1'b0;
        cand = 0;
        if (!rst) begin
            for (int i = 0; i < int'(CHANS); i++) begin
                cand = (int'(ptr_q) + i) % CHANS;
                if (!xfer && req[cand]) begin
                    xfer      = 1'b1;
                    gnt[cand] = 1'b1;
                    gidx      = CW'(cand);
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = CW'((int'(gidx) + 1) % CHANS);
        end
    end

    assign gaddr = addr[gidx*AW +: AW];

    // Unmatched (out-of-range) addresses fall through to zero.
    always_comb begin
        rom_word = '0;
        for (int b = 0; b < int'(BLKS); b++) begin
            for (int e = 0; e < int'(BDEPTH); e++) begin
                if (NENT == 1 || int'(gaddr) == b * int'(BDEPTH) + e) begin
                    rom_word = ROMVAL[b][e];
                end
            end
        end
    end

    // Word and tag only advance with a valid, so the last stage holds its data when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            vld_q <= '0;
            for (int i = 0; i < int'(RDLAT); i++) begin
                chan_q[i] <= '0;
                word_q[i] <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            vld_q[0] <= xfer;
            if (xfer) begin
                chan_q[0] <= gidx;
                word_q[0] <= rom_word;
            end
            for (int i = 1; i < int'(RDLAT); i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    chan_q[i] <= chan_q[i-1];
                    word_q[i] <= word_q[i-1];
                end
            end
        end
    end

    always_comb begin
        rvalid = '0;
        if (vld_q[RDLAT-1]) begin
            rvalid[chan_q[RDLAT-1]] = 1'b1;
        end
    end

    assign rchan = chan_q[RDLAT-1];
    assign rdata = word_q[RDLAT-1];

endmodule
